// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared register-file definitions for the core.
//   RF_DATA_WIDTH      default architectural register width
//   RF_NUM_REGS        default architectural register count
//   RF_REG_ADDR_WIDTH  default register address width
//   rf_wr_port_t       one writeback bus {en, addr, data} at the default widths
package regfile_mp_scoreboard_pkg;

   localparam int RF_DATA_WIDTH     = 32;
   localparam int RF_NUM_REGS       = 32;
   localparam int RF_REG_ADDR_WIDTH = $clog2(RF_NUM_REGS);

   typedef struct packed {
      logic                         en;
      logic [RF_REG_ADDR_WIDTH-1:0] addr;
      logic [RF_DATA_WIDTH-1:0]     data;
   } rf_wr_port_t;

endpackage

// File: rtl/regfile_mp_scoreboard_rf_scoreboard.sv
// Write-pending scoreboard: one pending bit per architectural register.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   iss_valid   an instruction issues this cycle, marking iss_rd pending
//   iss_rd      destination register of the issuing instruction
//   flush       clear every pending bit (wins over a concurrent issue)
//   wr_en       per-port writeback enables
//   wr_addr     per-port writeback addresses, port w at [w*AW +: AW]
//   pending     registered pending vector
//   any_busy    OR of the registered pending vector
module rf_scoreboard
   import regfile_mp_scoreboard_pkg::*;
#(
   parameter int NUM_REGS     = RF_NUM_REGS,
   parameter int NUM_WR_PORTS = 1,
   parameter int ZERO_REG     = 1,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         iss_valid,
   input  logic [AW-1:0]                iss_rd,
   input  logic                         flush,
   input  logic [NUM_WR_PORTS-1:0]      wr_en,
   input  logic [NUM_WR_PORTS*AW-1:0]   wr_addr,
   output logic [NUM_REGS-1:0]          pending,
   output logic                         any_busy
);

   logic [NUM_REGS-1:0] pending_nxt;

   // Later assignments override earlier ones, which yields the required
   // priority: flush > issue set > writeback clear.
   always_comb begin
      pending_nxt = pending;
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
         if (wr_en[w]) pending_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (iss_valid) pending_nxt[iss_rd] = 1'b1;
      if (flush) pending_nxt = '0;
      // x0 has no producer to wait on, so its bit stays clear.
      if (ZERO_REG != 0) pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   assign any_busy = |pending;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with integrated write-pending scoreboard.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rd_addr     read addresses, port p at [p*AW +: AW]
//   rd_data     combinational read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy     read register still waits on a write not delivered this cycle
//   wr_en       writeback enables
//   wr_addr     writeback addresses, port w at [w*AW +: AW]
//   wr_data     writeback data, port w at [w*DATA_WIDTH +: DATA_WIDTH]
//   iss_valid   mark iss_rd pending
//   iss_rd      destination of the issuing instruction
//   flush       clear all pending bits
//   any_busy    OR of all registered pending bits
module regfile_mp_scoreboard
   import regfile_mp_scoreboard_pkg::*;
#(
   parameter int DATA_WIDTH   = RF_DATA_WIDTH,
   parameter int NUM_REGS     = RF_NUM_REGS,
   parameter int NUM_RD_PORTS = 2,
   parameter int NUM_WR_PORTS = 1,
   parameter int ZERO_REG     = 1,
   parameter int BYPASS       = 1,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD_PORTS-1:0]            rd_busy,
   input  logic [NUM_WR_PORTS-1:0]            wr_en,
   input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr,
   input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
   input  logic                               iss_valid,
   input  logic [AW-1:0]                      iss_rd,
   input  logic                               flush,
   output logic                               any_busy
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   pending;

   rf_scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .ZERO_REG     (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .pending   (pending),
      .any_busy  (any_busy)
   );

   // Ports are applied in ascending order so the highest-index port wins
   // when two ports target the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0)))
               regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [AW-1:0]         addr;
      logic [DATA_WIDTH-1:0] byp_data;
      logic                  wr_hit;
      logic                  is_zero;

      assign addr    = rd_addr[p*AW +: AW];
      assign is_zero = (ZERO_REG != 0) && (addr == '0);

      // Scan upward so the highest-index matching write port supplies the data.
      always_comb begin
         byp_data = '0;
         wr_hit   = 1'b0;
         for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
               byp_data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
               wr_hit   = 1'b1;
            end
         end
      end

      always_comb begin
         if (is_zero)                        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
         else if ((BYPASS != 0) && wr_hit)   rd_data[p*DATA_WIDTH +: DATA_WIDTH] = byp_data;
         else                                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
      end

      // A same-cycle issue is deliberately not visible here; the pending bit
      // it sets shows up on the following cycle.
      assign rd_busy[p] = pending[addr] && !((BYPASS != 0) && wr_hit) && !is_zero;
   end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard (2 read ports, 2 write ports,
// ZERO_REG=1, BYPASS=1) with a behavioural model checked every cycle.
module tb_regfile_mp_scoreboard;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int NRP = 2;
   localparam int NWP = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NRP*AW-1:0] rd_addr = '0;
   logic [NRP*DW-1:0] rd_data;
   logic [NRP-1:0]    rd_busy;
   logic [NWP-1:0]    wr_en = '0;
   logic [NWP*AW-1:0] wr_addr = '0;
   logic [NWP*DW-1:0] wr_data = '0;
   logic              iss_valid = 1'b0;
   logic [AW-1:0]     iss_rd = '0;
   logic              flush = 1'b0;
   logic              any_busy;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model state
   logic [DW-1:0] m_regs [NR];
   bit            m_pend [NR];

   regfile_mp_scoreboard #(
      .DATA_WIDTH   (DW),
      .NUM_REGS     (NR),
      .NUM_RD_PORTS (NRP),
      .NUM_WR_PORTS (NWP),
      .ZERO_REG     (1),
      .BYPASS       (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .any_busy  (any_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: a register is pending after a clock if flush is low and it was
   // issued, or it was pending and not written back. Writes land in port
   // order, x0 never changes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
         end
      end else begin
         bit written [NR];
         for (int r = 0; r < NR; r++) written[r] = 1'b0;
         for (int w = 0; w < NWP; w++) begin
            if (wr_en[w]) begin
               written[wr_addr[w*AW +: AW]] = 1'b1;
               if (wr_addr[w*AW +: AW] != 0) m_regs[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
            end
         end
         for (int r = 1; r < NR; r++) begin
            if (flush)                          m_pend[r] = 1'b0;
            else if (iss_valid && iss_rd == r)  m_pend[r] = 1'b1;
            else if (written[r])                m_pend[r] = 1'b0;
         end
         m_pend[0] = 1'b0;
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit any;
         any = 1'b0;
         for (int r = 0; r < NR; r++) any |= m_pend[r];
         check("model any_busy", {31'd0, any_busy}, {31'd0, any});
         for (int p = 0; p < NRP; p++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] ed;
            bit            hit;
            a   = rd_addr[p*AW +: AW];
            ed  = m_regs[a];
            hit = 1'b0;
            for (int w = NWP - 1; w >= 0; w--) begin
               if (!hit && wr_en[w] && wr_addr[w*AW +: AW] == a) begin
                  hit = 1'b1;
                  ed  = wr_data[w*DW +: DW];
               end
            end
            if (a == 0) ed = '0;
            check($sformatf("model rd_data%0d", p), rd_data[p*DW +: DW], ed);
            check($sformatf("model rd_busy%0d", p), {31'd0, rd_busy[p]},
                  {31'd0, (m_pend[a] && !hit && a != 0)});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en     = '0;
      iss_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[w]             = 1'b1;
      wr_addr[w*AW +: AW]  = a;
      wr_data[w*DW +: DW]  = d;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      iss_valid = 1'b1;
      iss_rd    = a;
   endtask

   initial begin
      // Reset: all reads return zero, nothing busy
      #2;
      chk_en = 1'b1;
      for (int a = 0; a < NR; a += 2) begin
         rd(0, a[AW-1:0]);
         rd(1, a[AW-1:0] + 5'd1);
         #1;
         check("rst rd_data0", rd_data[0 +: DW], 32'h0);
         check("rst rd_data1", rd_data[DW +: DW], 32'h0);
         check("rst rd_busy", {30'd0, rd_busy}, 32'h0);
      end
      check("rst any_busy", {31'd0, any_busy}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Bypass then stored value
      wr(0, 5, 32'hDEADBEEF); rd(0, 5);
      #1 check("byp same cycle", rd_data[0 +: DW], 32'hDEADBEEF);
      tick(); idle();
      #1 check("byp stored", rd_data[0 +: DW], 32'hDEADBEEF);
      tick();

      // x0 hardwired
      wr(0, 0, 32'h1234); iss(0); rd(0, 0);
      #1 check("x0 data same", rd_data[0 +: DW], 32'h0);
      check("x0 busy same", {31'd0, rd_busy[0]}, 32'h0);
      tick(); idle();
      #1 check("x0 data", rd_data[0 +: DW], 32'h0);
      check("x0 busy", {31'd0, rd_busy[0]}, 32'h0);
      check("x0 any_busy", {31'd0, any_busy}, 32'h0);
      tick();

      // Scoreboard issue / writeback
      iss(7); rd(0, 7);
      #1 check("iss not same cycle", {31'd0, rd_busy[0]}, 32'h0);
      tick(); idle();
      #1 check("x7 busy", {31'd0, rd_busy[0]}, 32'h1);
      check("x7 any_busy", {31'd0, any_busy}, 32'h1);
      tick();
      wr(0, 7, 32'h55);
      #1 check("x7 wb busy", {31'd0, rd_busy[0]}, 32'h0);
      check("x7 wb data", rd_data[0 +: DW], 32'h55);
      check("x7 wb any_busy reg", {31'd0, any_busy}, 32'h1);
      tick(); idle();
      #1 check("x7 cleared", {31'd0, rd_busy[0]}, 32'h0);
      check("x7 any_busy clr", {31'd0, any_busy}, 32'h0);
      tick();

      // Collision: issue beats writeback; highest write port wins
      iss(9); wr(0, 9, 32'hAB); rd(0, 9);
      tick(); idle();
      #1 check("x9 still busy", {31'd0, rd_busy[0]}, 32'h1);
      check("x9 data", rd_data[0 +: DW], 32'hAB);
      wr(0, 3, 32'h1); wr(1, 3, 32'h2); rd(1, 3);
      #1 check("x3 byp hi port", rd_data[DW +: DW], 32'h2);
      tick(); idle();
      #1 check("x3 stored", rd_data[DW +: DW], 32'h2);
      wr(1, 9, 32'hCD);
      tick(); idle();
      #1 check("x9 cleared", {31'd0, any_busy}, 32'h0);
      tick();

      // Flush
      iss(4); tick(); iss(6); tick(); iss(8); tick(); idle();
      rd(0, 4); rd(1, 6);
      #1 check("flush pre any", {31'd0, any_busy}, 32'h1);
      check("flush pre busy", {30'd0, rd_busy}, 32'h3);
      flush = 1'b1; iss(10); wr(0, 4, 32'h77);
      #1 check("flush byp x4", rd_data[0 +: DW], 32'h77);
      check("flush busy same", {30'd0, rd_busy}, 32'h2);
      tick(); idle(); rd(1, 10);
      #1 check("flush any_busy", {31'd0, any_busy}, 32'h0);
      check("flush x10 busy", {31'd0, rd_busy[1]}, 32'h0);
      check("flush x4 data", rd_data[0 +: DW], 32'h77);
      tick();

      // Asynchronous reset mid-operation
      iss(12); tick(); idle(); rd(0, 12); rd(1, 5);
      #1 check("pre-rst busy", {31'd0, rd_busy[0]}, 32'h1);
      #1 rst_n = 1'b0;
      #1 check("mid-rst any", {31'd0, any_busy}, 32'h0);
      check("mid-rst x5", rd_data[DW +: DW], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
